// File: rtl/address_lookup.sv
// Read-side lookup engine for the MAC learning table: scans entries through a
// synchronous read port and returns the egress port, or a flood indication.
module address_lookup #(
    parameter int unsigned NUM_ENTRIES = 16,
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned IDX_W       = $clog2(NUM_ENTRIES),
    parameter int unsigned PORT_W      = $clog2(NUM_PORTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [47:0]       req_mac,
    output logic              rd_en,
    output logic [IDX_W-1:0]  rd_index,
    input  logic              rd_used,
    input  logic [47:0]       rd_mac,
    input  logic [PORT_W-1:0] rd_port,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic              rsp_flood,
    output logic [PORT_W-1:0] rsp_port,
    output logic [IDX_W-1:0]  rsp_index,
    output logic              hit_inc_valid,
    output logic [IDX_W-1:0]  hit_inc_index
);

    localparam int unsigned     CNT_W    = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_ENTRIES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

    state_e              state_q, state_d;
    logic [47:0]         mac_q, mac_d;
    logic                req_ready_q, req_ready_d;
    logic                rd_en_q, rd_en_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic                cmp_vld_q, cmp_vld_d;
    logic [IDX_W-1:0]    cmp_idx_q, cmp_idx_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_hit_q, rsp_hit_d;
    logic                rsp_flood_q, rsp_flood_d;
    logic [PORT_W-1:0]   rsp_port_q, rsp_port_d;
    logic [IDX_W-1:0]    rsp_index_q, rsp_index_d;
    logic                hit_inc_valid_q, hit_inc_valid_d;
    logic [IDX_W-1:0]    hit_inc_index_q, hit_inc_index_d;
    logic                match_c;

    // Read data returned this cycle belongs to the read issued last cycle.
    assign match_c = cmp_vld_q && rd_used && (rd_mac == mac_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            mac_q           <= 48'd0;
            req_ready_q     <= 1'b1;
            rd_en_q         <= 1'b0;
            rd_cnt_q        <= '0;
            cmp_vld_q       <= 1'b0;
            cmp_idx_q       <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_hit_q       <= 1'b0;
            rsp_flood_q     <= 1'b0;
            rsp_port_q      <= '0;
            rsp_index_q     <= '0;
            hit_inc_valid_q <= 1'b0;
            hit_inc_index_q <= '0;
        end else begin
            state_q         <= state_d;
            mac_q           <= mac_d;
            req_ready_q     <= req_ready_d;
            rd_en_q         <= rd_en_d;
            rd_cnt_q        <= rd_cnt_d;
            cmp_vld_q       <= cmp_vld_d;
            cmp_idx_q       <= cmp_idx_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_hit_q       <= rsp_hit_d;
            rsp_flood_q     <= rsp_flood_d;
            rsp_port_q      <= rsp_port_d;
            rsp_index_q     <= rsp_index_d;
            hit_inc_valid_q <= hit_inc_valid_d;
            hit_inc_index_q <= hit_inc_index_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        mac_d           = mac_q;
        req_ready_d     = req_ready_q;
        rd_en_d         = rd_en_q;
        rd_cnt_d        = rd_cnt_q;
        cmp_vld_d       = cmp_vld_q;
        cmp_idx_d       = cmp_idx_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_hit_d       = rsp_hit_q;
        rsp_flood_d     = rsp_flood_q;
        rsp_port_d      = rsp_port_q;
        rsp_index_d     = rsp_index_q;
        hit_inc_valid_d = 1'b0;
        hit_inc_index_d = hit_inc_index_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    mac_d       = req_mac;
                    req_ready_d = 1'b0;
                    if (req_mac[40]) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_hit_d   = 1'b0;
                        rsp_flood_d = 1'b1;
                        rsp_port_d  = '0;
                        rsp_index_d = '0;
                    end else begin
                        state_d   = SCAN;
                        rd_en_d   = 1'b1;
                        rd_cnt_d  = '0;
                        cmp_vld_d = 1'b0;
                    end
                end
            end
            SCAN: begin
                cmp_vld_d = rd_en_q;
                cmp_idx_d = rd_cnt_q[IDX_W-1:0];
                // Index counter saturates at the last entry instead of wrapping.
                if (rd_en_q) begin
                    if (rd_cnt_q == CNT_LAST) begin
                        rd_en_d = 1'b0;
                    end else begin
                        rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    end
                end
                if (match_c) begin
                    state_d         = RESP;
                    rd_en_d         = 1'b0;
                    rd_cnt_d        = rd_cnt_q;
                    cmp_vld_d       = 1'b0;
                    rsp_valid_d     = 1'b1;
                    rsp_hit_d       = 1'b1;
                    rsp_flood_d     = 1'b0;
                    rsp_port_d      = rd_port;
                    rsp_index_d     = cmp_idx_q;
                    hit_inc_valid_d = 1'b1;
                    hit_inc_index_d = cmp_idx_q;
                end else if (cmp_vld_q && (cmp_idx_q == IDX_LAST)) begin
                    state_d     = RESP;
                    rd_en_d     = 1'b0;
                    cmp_vld_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = 1'b0;
                    rsp_flood_d = 1'b1;
                    rsp_port_d  = '0;
                    rsp_index_d = '0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_hit_d   = 1'b0;
                    rsp_flood_d = 1'b0;
                    rsp_port_d  = '0;
                    rsp_index_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready     = req_ready_q;
    assign rd_en         = rd_en_q;
    assign rd_index      = rd_cnt_q[IDX_W-1:0];
    assign rsp_valid     = rsp_valid_q;
    assign rsp_hit       = rsp_hit_q;
    assign rsp_flood     = rsp_flood_q;
    assign rsp_port      = rsp_port_q;
    assign rsp_index     = rsp_index_q;
    assign hit_inc_valid = hit_inc_valid_q;
    assign hit_inc_index = hit_inc_index_q;

endmodule

// File: tb/tb_address_lookup.sv
// Self-checking bench for address_lookup: table memory model plus a
// first-match reference model computed directly from the table contents.
module tb_address_lookup;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [47:0] req_mac;
    logic        rd_en;
    logic [3:0]  rd_index;
    logic        rd_used;
    logic [47:0] rd_mac;
    logic [1:0]  rd_port;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic        rsp_flood;
    logic [1:0]  rsp_port;
    logic [3:0]  rsp_index;
    logic        hit_inc_valid;
    logic [3:0]  hit_inc_index;

    int n_checks = 0;
    int n_fail   = 0;

    logic        t_used [N];
    logic [47:0] t_mac  [N];
    logic [1:0]  t_port [N];

    address_lookup #(.NUM_ENTRIES(16), .NUM_PORTS(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mac(req_mac),
        .rd_en(rd_en), .rd_index(rd_index),
        .rd_used(rd_used), .rd_mac(rd_mac), .rd_port(rd_port),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hit(rsp_hit), .rsp_flood(rsp_flood),
        .rsp_port(rsp_port), .rsp_index(rsp_index),
        .hit_inc_valid(hit_inc_valid), .hit_inc_index(hit_inc_index)
    );

    always #5 clk = ~clk;

    // Synchronous read port; junk data when not reading.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_used <= t_used[rd_index];
            rd_mac  <= t_mac[rd_index];
            rd_port <= t_port[rd_index];
        end else begin
            rd_used <= 1'($urandom);
            rd_mac  <= {$urandom, $urandom};
            rd_port <= 2'($urandom);
        end
    end

    function automatic logic [47:0] rand_ucast();
        logic [47:0] m;
        m = {16'($urandom), $urandom};
        m[40] = 1'b0;
        return m;
    endfunction

    task automatic clear_table();
        for (int i = 0; i < N; i++) begin
            t_used[i] = 1'b0;
            t_mac[i]  = rand_ucast();
            t_port[i] = 2'($urandom);
        end
    endtask

    // Reference: lowest used entry with equal MAC wins; latency follows the scan order.
    function automatic void ref_lookup(input logic [47:0] mac, output logic [7:0] e_res,
                                       output int e_lat, output int e_rds);
        e_res = {1'b0, 1'b1, 2'd0, 4'd0};
        if (mac[40]) begin
            e_lat = 1;
            e_rds = 0;
            return;
        end
        e_lat = N + 2;
        e_rds = N;
        for (int i = 0; i < N; i++) begin
            if (t_used[i] && t_mac[i] == mac) begin
                e_res = {1'b1, 1'b0, t_port[i], 4'(i)};
                e_lat = i + 3;
                e_rds = (i + 2 < N) ? i + 2 : N;
                return;
            end
        end
    endfunction

    // Drives one request, holds rsp_ready low for 'stall' response cycles, records observations.
    task automatic run_lookup(input logic [47:0] mac, input int stall,
                              output int lat, output logic [7:0] res,
                              output int inc_cnt, output logic [3:0] inc_idx,
                              output int rd_cnt, output int seq_err,
                              output int stable_err, output int ready_err,
                              output logic after_ready);
        int c;
        int wait_cnt;
        bit done;
        lat = -1; res = 8'hxx; inc_cnt = 0; inc_idx = 4'd0; rd_cnt = 0;
        seq_err = 0; stable_err = 0; ready_err = 0; wait_cnt = 0; done = 1'b0; c = 0;
        @(negedge clk);
        if (req_ready !== 1'b1) ready_err++;
        req_valid = 1'b1;
        req_mac   = mac;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_mac   = rand_ucast();
        while (!done && c < 60) begin
            @(negedge clk);
            c++;
            if (req_ready !== 1'b0) ready_err++;
            if (hit_inc_valid === 1'b1) begin
                inc_cnt++;
                inc_idx = hit_inc_index;
            end
            if (rd_en === 1'b1) begin
                if (rd_index !== 4'(rd_cnt) || c != rd_cnt + 1 || rsp_valid === 1'b1) seq_err++;
                rd_cnt++;
            end
            if (rsp_valid === 1'b1) begin
                if (wait_cnt == 0) begin
                    lat = c;
                    res = {rsp_hit, rsp_flood, rsp_port, rsp_index};
                end else if (res !== {rsp_hit, rsp_flood, rsp_port, rsp_index}) begin
                    stable_err++;
                end
                wait_cnt++;
                if (wait_cnt > stall) begin
                    rsp_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    rsp_ready = 1'b0;
                    done = 1'b1;
                end
            end
        end
        @(negedge clk);
        after_ready = req_ready;
        if (hit_inc_valid === 1'b1) inc_cnt++;
        if (rsp_valid !== 1'b0) stable_err++;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_mac = 48'd0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready, rd_en, rd_index, rsp_valid, rsp_hit, rsp_flood, rsp_port, rsp_index,
             hit_inc_valid, hit_inc_index} !== {1'b1, 19'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got req_ready=%b rd_en=%b rd_index=%0d rsp_valid=%b hit=%b flood=%b port=%0d idx=%0d inc=%b inc_idx=%0d, expected req_ready=1 and all else 0",
                     req_ready, rd_en, rd_index, rsp_valid, rsp_hit, rsp_flood, rsp_port, rsp_index,
                     hit_inc_valid, hit_inc_index);
        end
        rst = 1'b0;
    endtask

    task automatic test_hit_basic();
        logic [7:0] res, e_res; logic [3:0] inc_idx; logic ar;
        int lat, inc_cnt, rds, se, st, re, e_lat, e_rds;
        clear_table();
        for (int i = 0; i < N; i++) t_used[i] = (i != 5);
        t_mac[5] = 48'h00_11_22_33_44_55; t_port[5] = 2'd2; t_used[5] = 1'b1;
        ref_lookup(48'h001122334455, e_res, e_lat, e_rds);
        run_lookup(48'h001122334455, 0, lat, res, inc_cnt, inc_idx, rds, se, st, re, ar);
        n_checks++;
        if (lat != 8 || lat != e_lat) begin n_fail++; $display("FAIL hit_basic_latency: got %0d expected 8", lat); end
        n_checks++;
        if (res !== {1'b1, 1'b0, 2'd2, 4'd5}) begin n_fail++; $display("FAIL hit_basic_result: got %h expected %h", res, {1'b1, 1'b0, 2'd2, 4'd5}); end
        n_checks++;
        if (inc_cnt != 1 || inc_idx !== 4'd5) begin n_fail++; $display("FAIL hit_basic_inc: got count=%0d idx=%0d expected 1 and 5", inc_cnt, inc_idx); end
        n_checks++;
        if (rds != e_rds || se != 0) begin n_fail++; $display("FAIL hit_basic_reads: got %0d reads (%0d order errors) expected %0d", rds, se, e_rds); end
    endtask

    task automatic test_miss_empty();
        logic [7:0] res; logic [3:0] inc_idx; logic ar;
        int lat, inc_cnt, rds, se, st, re;
        clear_table();
        t_mac[7] = 48'h00_AA_BB_CC_DD_EE;
        run_lookup(48'h00AABBCCDDEE, 0, lat, res, inc_cnt, inc_idx, rds, se, st, re, ar);
        n_checks++;
        if (lat != 18) begin n_fail++; $display("FAIL miss_latency: got %0d expected 18", lat); end
        n_checks++;
        if (res !== 8'b0100_0000) begin n_fail++; $display("FAIL miss_result: got %h expected 40", res); end
        n_checks++;
        if (rds != 16 || se != 0 || inc_cnt != 0) begin n_fail++; $display("FAIL miss_sweep: got reads=%0d order_err=%0d inc=%0d expected 16 0 0", rds, se, inc_cnt); end
    endtask

    task automatic test_group();
        logic [47:0] macs [2];
        logic [7:0] res; logic [3:0] inc_idx; logic ar;
        int lat, inc_cnt, rds, se, st, re;
        macs[0] = 48'hFF_FF_FF_FF_FF_FF;
        macs[1] = 48'h01_00_5E_00_00_01;
        clear_table();
        for (int g = 0; g < 2; g++) begin
            t_used[2] = 1'b1; t_mac[2] = macs[g];
            run_lookup(macs[g], 0, lat, res, inc_cnt, inc_idx, rds, se, st, re, ar);
            n_checks++;
            if (lat != 1 || res !== 8'b0100_0000) begin n_fail++; $display("FAIL group_%0d: got lat=%0d res=%h expected lat=1 res=40", g, lat, res); end
            n_checks++;
            if (rds != 0 || inc_cnt != 0) begin n_fail++; $display("FAIL group_noread_%0d: got reads=%0d inc=%0d expected 0 0", g, rds, inc_cnt); end
        end
    endtask

    task automatic test_duplicate();
        logic [47:0] m;
        logic [7:0] res; logic [3:0] inc_idx; logic ar;
        int lat, inc_cnt, rds, se, st, re;
        clear_table();
        m = rand_ucast();
        t_used[3] = 1'b1; t_mac[3] = m; t_port[3] = 2'd1;
        t_used[9] = 1'b1; t_mac[9] = m; t_port[9] = 2'd3;
        run_lookup(m, 0, lat, res, inc_cnt, inc_idx, rds, se, st, re, ar);
        n_checks++;
        if (lat != 6 || res !== {1'b1, 1'b0, 2'd1, 4'd3}) begin n_fail++; $display("FAIL duplicate_first: got lat=%0d res=%h expected lat=6 res=%h", lat, res, {1'b1, 1'b0, 2'd1, 4'd3}); end
        // Index 4 is the single in-flight read when index 3 compares; nothing past it.
        n_checks++;
        if (rds != 5 || se != 0) begin n_fail++; $display("FAIL duplicate_reads: got reads=%0d order_err=%0d expected 5 0", rds, se); end
    endtask

    task automatic test_stall();
        logic [7:0] res; logic [3:0] inc_idx; logic ar;
        int lat, inc_cnt, rds, se, st, re;
        clear_table();
        t_used[0] = 1'b1; t_port[0] = 2'd3;
        run_lookup(t_mac[0], 10, lat, res, inc_cnt, inc_idx, rds, se, st, re, ar);
        n_checks++;
        if (lat != 3 || res !== {1'b1, 1'b0, 2'd3, 4'd0}) begin n_fail++; $display("FAIL stall_result: got lat=%0d res=%h expected lat=3 res=%h", lat, res, {1'b1, 1'b0, 2'd3, 4'd0}); end
        n_checks++;
        if (st != 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes expected 0", st); end
        n_checks++;
        if (inc_cnt != 1 || inc_idx !== 4'd0) begin n_fail++; $display("FAIL stall_inc: got count=%0d idx=%0d expected 1 0", inc_cnt, inc_idx); end
        n_checks++;
        if (re != 0 || ar !== 1'b1) begin n_fail++; $display("FAIL stall_ready: got busy_errs=%0d after=%b expected 0 1", re, ar); end
    endtask

    task automatic test_random();
        logic [47:0] m;
        logic [7:0] res, e_res; logic [3:0] inc_idx; logic ar;
        int lat, inc_cnt, rds, se, st, re, e_lat, e_rds, stall, k;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                t_used[i] = 1'($urandom);
                t_mac[i]  = rand_ucast();
                t_port[i] = 2'($urandom);
            end
            k = int'($urandom_range(N - 1));
            t_mac[$urandom_range(N - 1)] = t_mac[k];
            case ($urandom_range(3))
                0: m = rand_ucast();
                1: begin m = {16'($urandom), $urandom}; m[40] = 1'b1; end
                default: m = t_mac[k];
            endcase
            stall = int'($urandom_range(3));
            ref_lookup(m, e_res, e_lat, e_rds);
            run_lookup(m, stall, lat, res, inc_cnt, inc_idx, rds, se, st, re, ar);
            n_checks++;
            if (lat != e_lat) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", it, lat, e_lat); end
            n_checks++;
            if (res !== e_res) begin n_fail++; $display("FAIL rand_result[%0d]: got %h expected %h", it, res, e_res); end
            n_checks++;
            if (inc_cnt != int'(e_res[7]) || (e_res[7] && inc_idx !== e_res[3:0])) begin
                n_fail++; $display("FAIL rand_inc[%0d]: got count=%0d idx=%0d expected %0d %0d", it, inc_cnt, inc_idx, e_res[7], e_res[3:0]);
            end
            n_checks++;
            if (rds != e_rds || se != 0 || st != 0 || re != 0 || ar !== 1'b1) begin
                n_fail++; $display("FAIL rand_protocol[%0d]: got reads=%0d/%0d order=%0d stable=%0d ready=%0d after=%b", it, rds, e_rds, se, st, re, ar);
            end
        end
    endtask

    task automatic test_reset_abort();
        int c, bad;
        clear_table();
        t_used[12] = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_mac = t_mac[12];
        @(posedge clk);
        #1 req_valid = 1'b0;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(rd_en === 1'b1 && rd_index === 4'd7) && c < 30);
        n_checks++;
        if (c >= 30) begin n_fail++; $display("FAIL abort_reach_idx7: got timeout expected rd_index=7"); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready, rd_en, rd_index, rsp_valid, rsp_hit, rsp_flood, rsp_port, rsp_index,
             hit_inc_valid, hit_inc_index} !== {1'b1, 19'd0}) begin
            n_fail++; $display("FAIL abort_outputs: got req_ready=%b rd_en=%b rd_index=%0d rsp_valid=%b inc=%b expected 1 0 0 0 0", req_ready, rd_en, rd_index, rsp_valid, hit_inc_valid);
        end
        rst = 1'b0;
        rsp_ready = 1'b1;
        bad = 0;
        repeat (25) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || hit_inc_valid !== 1'b0 || req_ready !== 1'b1) bad++;
        end
        rsp_ready = 1'b0;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL abort_quiet: got %0d bad cycles expected 0", bad); end
    endtask

    initial begin
        rd_used = 1'b0; rd_mac = 48'd0; rd_port = 2'd0;
        test_reset();
        test_hit_basic();
        test_miss_empty();
        test_group();
        test_duplicate();
        test_stall();
        test_random();
        test_reset_abort();
        test_hit_basic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
